b_to_g_enc: RTL
===============

Name: b_to_g_enc

Overview:
- Streaming binary-to-Gray encoder. It accepts binary words on a valid/ready input and emits registered Gray words on a valid/ready output.
- Throughput is one word per cycle. A 2-entry skid path (output register plus skid register) breaks backpressure timing.
- A counter mode generates the full Gray sequence internally. Used for pointer generation and for stimulus toward the Gray-to-binary decode path.

Parameters:
- WIDTH, 4, bit width of the binary input and the Gray output (min 2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  in_bin is valid (stream mode only).
- in_ready  output  1  block accepts in_bin this cycle.
- in_bin  input  WIDTH  binary word to encode.
- cnt_mode  input  1  0 = stream mode, 1 = internal counter mode.
- cnt_en  input  1  counter mode: allow the counter to push a word.
- out_valid  output  1  out_gray/out_bin/out_last are valid.
- out_ready  input  1  downstream accepts the output word this cycle.
- out_gray  output  WIDTH  Gray-encoded word, equal to b ^ (b >> 1).
- out_bin  output  WIDTH  binary source of out_gray, carried alongside it.
- out_last  output  1  counter mode: word is the all-ones binary value (sequence end). Always 0 in stream mode.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state = ST_EMPTY; out_valid=0, in_ready=0, out_gray=0, out_bin=0, out_last=0.
  - Counter cleared to 0; mode_q cleared to 0; skid contents discarded.
  - Reset mid-transfer drops all held words. No partial word appears after reset.
- in_ready is registered. It equals (state != ST_TWO) && (mode_q == 0) and is first 1 in the cycle after reset release.
- Push:
  - Stream mode: push = in_valid && in_ready.
  - Counter mode: push = cnt_en && (state != ST_TWO).
- Pop = out_valid && out_ready.
- Latency: a word pushed at edge N is visible on out_* after edge N when the output register is empty or popping. Otherwise it is held in the skid register. Order is always preserved.
- FSM states and transitions:
  - ST_EMPTY: push -> ST_ONE (word into output register).
  - ST_ONE:
    - push and no pop -> ST_TWO (word into skid).
    - pop and no push -> ST_EMPTY.
    - push and pop together -> stays ST_ONE; the new word goes into the output register.
  - ST_TWO:
    - pop -> ST_ONE; the skid word moves to the output register.
    - push is impossible (in_ready=0 / counter stalled).
- out_valid = (state != ST_EMPTY). out_* hold stable while out_valid && !out_ready.
- Encoding is done on the push path; registers store Gray, binary and last together.
- Counter mode:
  - Counter increments by 1 on each push.
  - Wraps from 2^WIDTH-1 to 0 with no gap cycle.
  - out_last travels with the word whose binary value is all ones.
- Mode switch: cnt_mode is sampled into mode_q only in ST_EMPTY. Changes while words are held are ignored until the pipe drains. The counter is not cleared on a mode switch.
- in_bin is ignored in counter mode; cnt_en is ignored in stream mode.

Optional Feature:
- Macro: B2G_CHECK_EN.
- When defined:
  - Adds output port chk_err (1 bit).
  - An internal Gray-to-binary decode of out_gray is compared with out_bin whenever out_valid=1.
  - A mismatch sets chk_err on the next edge. chk_err is sticky and cleared only by reset (reset value 0).
- When undefined: no port and no logic. Behaviour is otherwise identical.

Decomposition:
- Package b2g_pkg holds:
  - WIDTH_DEFAULT constant.
  - typedef enum for states ST_EMPTY, ST_ONE, ST_TWO.
  - Packed struct typedef {gray, bin, last} for a stored entry.
- Sub-module bin2gray_core (purely combinational, parameter WIDTH) performs the encode. Instantiated once on the push path.
- The checker decode stays inline under the macro.

Test Plan:
- Stream mode, WIDTH=4, out_ready=1: push 0101, 1000, 1111 on consecutive cycles -> out_gray 0111, 1100, 1000 on consecutive cycles, 1-cycle latency, out_last=0.
- Backpressure: out_ready=0, in_valid=1 for 3 cycles with 0001, 0010, 0011 -> only two accepted, in_ready=0 after the second. Then out_ready=1 -> outputs 0001, 0011 in order, in_ready returns to 1.
- Counter mode, cnt_en=1, out_ready=1 -> out_gray 0000, 0001, 0011, 0010, 0110 ... 1000 (out_last=1 with out_bin=1111), then 0000 with no gap.
- Mode switch with 2 words held: cnt_mode 0->1 -> no counter word emitted until both stream words pop; counter words then follow.
- Reset mid-operation: ST_TWO held, rst_n=0 for one edge -> out_valid=0 and in_ready=0 that cycle. Counter restarts at 0000; held words are never emitted.
- With B2G_CHECK_EN: run the 16-value counter sweep -> chk_err stays 0. Force a corrupted out_gray via bench force -> chk_err=1 next edge, stays 1 until reset.

Source files
------------

// File: rtl/b2g_pkg.sv
// Shared types and constants for the streaming binary-to-Gray encoder.
package b2g_pkg;

  localparam int WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  // Layout of one stored word at the default width; the top mirrors it per WIDTH.
  typedef struct packed {
    logic [WIDTH_DEFAULT-1:0] gray;
    logic [WIDTH_DEFAULT-1:0] bin;
    logic                     last;
  } entry_t;

endpackage

// File: rtl/b_to_g_enc_core.sv
// Purely combinational binary-to-Gray encode used on the push path.
module bin2gray_core #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);

  assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/b_to_g_enc.sv
// Streaming binary-to-Gray encoder with 2-entry skid buffer and internal counter mode.
// Optional macro B2G_CHECK_EN adds a sticky decode-consistency checker on chk_err.
module b_to_g_enc
  import b2g_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_bin,
  input  logic             cnt_mode,
  input  logic             cnt_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gray,
  output logic [WIDTH-1:0] out_bin,
  output logic             out_last
`ifdef B2G_CHECK_EN
  ,
  output logic             chk_err
`endif
);

  typedef struct packed {
    logic [WIDTH-1:0] gray;
    logic [WIDTH-1:0] bin;
    logic             last;
  } slot_t;

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic             in_ready_q, in_ready_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  slot_t            out_q, out_d;
  slot_t            skid_q, skid_d;

  logic [WIDTH-1:0] enc_bin;
  logic [WIDTH-1:0] enc_gray;
  slot_t            push_slot;
  logic             push;
  logic             pop;

  assign enc_bin = mode_q ? cnt_q : in_bin;

  bin2gray_core #(.WIDTH(WIDTH)) u_core (
    .bin_i  (enc_bin),
    .gray_o (enc_gray)
  );

  assign push_slot = '{gray: enc_gray, bin: enc_bin, last: mode_q && (cnt_q == ALL_ONES)};
  assign pop       = (state_q != ST_EMPTY) && out_ready;
  assign push      = mode_q ? (cnt_en && (state_q != ST_TWO)) : (in_valid && in_ready_q);

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    cnt_d   = cnt_q;
    // Mode only changes once the pipe is empty, so held words never mix modes.
    mode_d  = (state_q == ST_EMPTY) ? cnt_mode : mode_q;
    if (push && mode_q) begin
      cnt_d = cnt_q + 1'b1;
    end
    unique case (state_q)
      ST_EMPTY: begin
        if (push) begin
          out_d   = push_slot;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (push && !pop) begin
          skid_d  = push_slot;
          state_d = ST_TWO;
        end else if (pop && !push) begin
          state_d = ST_EMPTY;
        end else if (push && pop) begin
          out_d = push_slot;
        end
      end
      ST_TWO: begin
        if (pop) begin
          out_d   = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    in_ready_d = (state_d != ST_TWO) && !mode_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      mode_q     <= 1'b0;
      in_ready_q <= 1'b0;
      cnt_q      <= '0;
      out_q      <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      in_ready_q <= in_ready_d;
      cnt_q      <= cnt_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign out_gray  = out_q.gray;
  assign out_bin   = out_q.bin;
  assign out_last  = out_q.last;

`ifdef B2G_CHECK_EN
  logic             chk_err_q, chk_err_d;
  logic [WIDTH-1:0] chk_bin;

  // Each decoded bit is the XOR of all Gray bits at or above it.
  always_comb begin
    chk_bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      chk_bin[i] = ^(out_gray >> i);
    end
    chk_err_d = chk_err_q | (out_valid && (chk_bin != out_bin));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chk_err_q <= 1'b0;
    end else begin
      chk_err_q <= chk_err_d;
    end
  end

  assign chk_err = chk_err_q;
`endif

endmodule
